xbar_banks_pea_seq: RTL and testbench

XBAR_BANKS_PEA_SEQ -- requirements
Module: xbar_banks_pea_seq

---
 rtl/xbar_banks_pea_seq.sv | 143 ++++++++++++++
 tb/tb_xbar_banks_pea_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/xbar_banks_pea_seq.sv
// xbar_banks_pea_seq: table-driven sequencer producing registered crossbar selects for PE/bank routing
// Ports: clk_i/rst_i (async active-high); cfg_we_i/cfg_addr_i/cfg_sel_*_i/cfg_rep_i write the entry table;
// n_entries_i/n_loops_i/start_i launch a run; abort_i ends it; stall_i freezes it when XBAR_SEQ_STALL_EN is defined;
// busy_o/valid_o/done_o report status; sel_dmem_pea_o/sel_pea_dmem_o drive the crossbar.
module xbar_banks_pea_seq #(
  parameter int N_PE_PER_GROUP         = 4,
  parameter int N_BANKS_PER_STREAM     = 4,
  parameter int LOG_N_PE_PER_GROUP     = 2,
  parameter int LOG_N_BANKS_PER_STREAM = 2,
  parameter int N_CFG                  = 8,
  parameter int LOG_N_CFG              = $clog2(N_CFG),
  parameter int REP_W                  = 8,
  parameter int LOOP_W                 = 16
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         cfg_we_i,
  input  logic [LOG_N_CFG-1:0]                         cfg_addr_i,
  input  logic [N_PE_PER_GROUP*LOG_N_BANKS_PER_STREAM-1:0] cfg_sel_dmem_pea_i,
  input  logic [N_BANKS_PER_STREAM*LOG_N_PE_PER_GROUP-1:0] cfg_sel_pea_dmem_i,
  input  logic [REP_W-1:0]                             cfg_rep_i,
  input  logic [LOG_N_CFG:0]                           n_entries_i,
  input  logic [LOOP_W-1:0]                            n_loops_i,
  input  logic                                         start_i,
  input  logic                                         abort_i,
  input  logic                                         stall_i,
  output logic                                         busy_o,
  output logic                                         valid_o,
  output logic                                         done_o,
  output logic [N_PE_PER_GROUP*LOG_N_BANKS_PER_STREAM-1:0] sel_dmem_pea_o,
  output logic [N_BANKS_PER_STREAM*LOG_N_PE_PER_GROUP-1:0] sel_pea_dmem_o
);
  localparam int DW = N_PE_PER_GROUP*LOG_N_BANKS_PER_STREAM;
  localparam int PW = N_BANKS_PER_STREAM*LOG_N_PE_PER_GROUP;
  localparam int EW = LOG_N_CFG+1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic [LOG_N_CFG-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [LOOP_W-1:0]     loop_q, loop_d, n_loops_q, n_loops_d;
  logic [EW-1:0]         n_ent_q, n_ent_d;
  logic [DW-1:0]         sel_dmem_q, sel_dmem_d;
  logic [PW-1:0]         sel_pea_q, sel_pea_d;
  logic [DW-1:0]         tab_dmem [N_CFG];
  logic [PW-1:0]         tab_pea  [N_CFG];
  logic [REP_W-1:0]      tab_rep  [N_CFG];
  logic                  stall, last_rep, last_ent, last_loop;
`ifdef XBAR_SEQ_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif
  assign ptr_nxt   = ptr_q + LOG_N_CFG'(1);
  assign last_rep  = rep_q == tab_rep[ptr_q];
  assign last_ent  = ({1'b0, ptr_q} + EW'(1)) == n_ent_q;
  assign last_loop = loop_q == n_loops_q;
  assign busy_o         = state_q == RUN;
  assign valid_o        = (state_q == RUN) && !stall;
  assign done_o         = state_q == DONE;
  assign sel_dmem_pea_o = sel_dmem_q;
  assign sel_pea_dmem_o = sel_pea_q;
  // Selects are registered: the value for the next cycle is chosen here, so
  // launch loads entry 0 and every exit from RUN loads zero.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rep_d      = rep_q;
    loop_d     = loop_q;
    n_ent_d    = n_ent_q;
    n_loops_d  = n_loops_q;
    sel_dmem_d = sel_dmem_q;
    sel_pea_d  = sel_pea_q;
    case (state_q)
      IDLE: if (start_i && n_entries_i != '0 && n_entries_i <= EW'(N_CFG)) begin
        state_d    = RUN;
        ptr_d      = '0;
        rep_d      = '0;
        loop_d     = '0;
        n_ent_d    = n_entries_i;
        n_loops_d  = n_loops_i;
        sel_dmem_d = tab_dmem[0];
        sel_pea_d  = tab_pea[0];
      end
      RUN: if (abort_i) begin
        state_d    = IDLE;
        sel_dmem_d = '0;
        sel_pea_d  = '0;
      end else if (!stall) begin
        rep_d = last_rep ? '0 : rep_q + REP_W'(1);
        if (last_rep && !last_ent) begin
          ptr_d      = ptr_nxt;
          sel_dmem_d = tab_dmem[ptr_nxt];
          sel_pea_d  = tab_pea[ptr_nxt];
        end else if (last_rep && !last_loop) begin
          ptr_d      = '0;
          loop_d     = loop_q + LOOP_W'(1);
          sel_dmem_d = tab_dmem[0];
          sel_pea_d  = tab_pea[0];
        end else if (last_rep) begin
          state_d    = DONE;
          sel_dmem_d = '0;
          sel_pea_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rep_q      <= '0;
      loop_q     <= '0;
      n_ent_q    <= '0;
      n_loops_q  <= '0;
      sel_dmem_q <= '0;
      sel_pea_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rep_q      <= rep_d;
      loop_q     <= loop_d;
      n_ent_q    <= n_ent_d;
      n_loops_q  <= n_loops_d;
      sel_dmem_q <= sel_dmem_d;
      sel_pea_q  <= sel_pea_d;
    end
  end
  // The table is frozen while a run is in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CFG; i++) begin
        tab_dmem[i] <= '0;
        tab_pea[i]  <= '0;
        tab_rep[i]  <= '0;
      end
    end else if (cfg_we_i && state_q != RUN) begin
      tab_dmem[cfg_addr_i] <= cfg_sel_dmem_pea_i;
      tab_pea[cfg_addr_i]  <= cfg_sel_pea_dmem_i;
      tab_rep[cfg_addr_i]  <= cfg_rep_i;
    end
  end
endmodule

// File: tb/tb_xbar_banks_pea_seq.sv
// tb_xbar_banks_pea_seq: directed self-checking bench for xbar_banks_pea_seq
module tb_xbar_banks_pea_seq;
  logic       clk_i = 1'b0, rst_i = 1'b1;
  logic       cfg_we_i = 1'b0;
  logic [2:0] cfg_addr_i = '0;
  logic [7:0] cfg_sel_dmem_pea_i = '0, cfg_sel_pea_dmem_i = '0, cfg_rep_i = '0;
  logic [3:0] n_entries_i = '0;
  logic [15:0] n_loops_i = '0;
  logic       start_i = 1'b0, abort_i = 1'b0, stall_i = 1'b0;
  logic       busy_o, valid_o, done_o;
  logic [7:0] sel_dmem_pea_o, sel_pea_dmem_o;
  int         n_cmp = 0, n_err = 0, cnt;
  int         stall_exp, stall_valid;
  logic [7:0] exp_d [8];
  logic [7:0] exp_p [8];

  xbar_banks_pea_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_sel_dmem_pea_i(cfg_sel_dmem_pea_i), .cfg_sel_pea_dmem_i(cfg_sel_pea_dmem_i),
    .cfg_rep_i(cfg_rep_i), .n_entries_i(n_entries_i), .n_loops_i(n_loops_i),
    .start_i(start_i), .abort_i(abort_i), .stall_i(stall_i), .busy_o(busy_o),
    .valid_o(valid_o), .done_o(done_o), .sel_dmem_pea_o(sel_dmem_pea_o),
    .sel_pea_dmem_o(sel_pea_dmem_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] p, input logic [7:0] r);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_sel_dmem_pea_i = d; cfg_sel_pea_dmem_i = p; cfg_rep_i = r;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic launch(input logic [3:0] ne, input logic [15:0] nl);
    n_entries_i = ne; n_loops_i = nl; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy_o}, 0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 0);
    chk({tag, "_done"}, {31'd0, done_o}, 0);
    chk({tag, "_sel"}, {16'd0, sel_dmem_pea_o, sel_pea_dmem_o}, 0);
  endtask

  task automatic wait_done(input string tag);
    cnt = 0;
    while (!done_o && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, "_done_seen"}, {31'd0, done_o}, 1);
    tick();
  endtask

  initial begin
`ifdef XBAR_SEQ_STALL_EN
    stall_exp = 3; stall_valid = 0;
`else
    stall_exp = 0; stall_valid = 1;
`endif
    #12;
    chk_zero("reset");
    rst_i = 1'b0;
    tick();
    chk_zero("idle");
    wr(3'd0, 8'h1B, 8'hE4, 8'd0);
    wr(3'd1, 8'h55, 8'hAA, 8'd2);

    // Two entries (rep 0 and 2), two passes.
    exp_d = '{8'h1B, 8'h55, 8'h55, 8'h55, 8'h1B, 8'h55, 8'h55, 8'h55};
    exp_p = '{8'hE4, 8'hAA, 8'hAA, 8'hAA, 8'hE4, 8'hAA, 8'hAA, 8'hAA};
    launch(4'd2, 16'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("seq_dmem%0d", i), {24'd0, sel_dmem_pea_o}, {24'd0, exp_d[i]});
      chk($sformatf("seq_pea%0d", i), {24'd0, sel_pea_dmem_o}, {24'd0, exp_p[i]});
      chk($sformatf("seq_valid%0d", i), {30'd0, busy_o, valid_o}, 3);
      chk($sformatf("seq_nodone%0d", i), {31'd0, done_o}, 0);
      tick();
    end
    chk("seq_done", {31'd0, done_o}, 1);
    chk("seq_done_busy", {31'd0, busy_o}, 0);
    chk("seq_done_sel", {16'd0, sel_dmem_pea_o, sel_pea_dmem_o}, 0);
    tick();
    chk_zero("seq_after");

    // Invalid entry counts are ignored.
    launch(4'd0, 16'd0);
    chk_zero("ne0");
    tick();
    chk_zero("ne0_later");
    launch(4'd9, 16'd0);
    chk_zero("ne9");

    // Stall three cycles inside entry 1.
    launch(4'd2, 16'd0);
    chk("st_e0", {24'd0, sel_dmem_pea_o}, 32'h1B);
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_sel%0d", i), {24'd0, sel_dmem_pea_o}, 32'h55);
      chk($sformatf("st_valid%0d", i), {31'd0, valid_o}, stall_valid);
      chk($sformatf("st_busy%0d", i), {31'd0, busy_o}, 1);
      tick();
    end
    stall_i = 1'b0;
    cnt = 0;
    while (!done_o && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("st_delay", cnt, stall_exp);
    tick();

    // Abort on the second RUN cycle.
    launch(4'd2, 16'd1);
    tick();
    abort_i = 1'b1;
    chk("ab_busy", {31'd0, busy_o}, 1);
    tick();
    abort_i = 1'b0;
    chk_zero("ab_next");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ab_nodone%0d", i), {31'd0, done_o}, 0);
      tick();
    end

    // Table write during RUN is ignored.
    launch(4'd2, 16'd0);
    chk("wr_run_e0", {24'd0, sel_dmem_pea_o}, 32'h1B);
    wr(3'd0, 8'hC3, 8'h3C, 8'd5);
    chk("wr_run_e1", {24'd0, sel_dmem_pea_o}, 32'h55);
    tick();
    tick();
    chk("wr_run_e1b", {24'd0, sel_pea_dmem_o}, 32'hAA);
    tick();
    chk("wr_run_done", {31'd0, done_o}, 1);
    tick();
    launch(4'd2, 16'd0);
    chk("wr_next_e0d", {24'd0, sel_dmem_pea_o}, 32'h1B);
    chk("wr_next_e0p", {24'd0, sel_pea_dmem_o}, 32'hE4);
    tick();
    chk("wr_next_rep", {24'd0, sel_dmem_pea_o}, 32'h55);
    wait_done("wr_next");
    wr(3'd0, 8'hC3, 8'h3C, 8'd1);
    launch(4'd1, 16'd0);
    chk("wr_idle_e0a", {16'd0, sel_dmem_pea_o, sel_pea_dmem_o}, 32'hC33C);
    tick();
    chk("wr_idle_e0b", {16'd0, sel_dmem_pea_o, sel_pea_dmem_o}, 32'hC33C);
    tick();
    chk("wr_idle_done", {31'd0, done_o}, 1);
    tick();

    // Asynchronous reset mid-RUN.
    launch(4'd2, 16'd1);
    tick();
    #2 rst_i = 1'b1;
    #1;
    chk_zero("arst");
    #1 rst_i = 1'b0;
    tick();
    chk_zero("arst_idle");
    launch(4'd1, 16'd0);
    chk("arst_tab_sel", {16'd0, sel_dmem_pea_o, sel_pea_dmem_o}, 0);
    chk("arst_tab_valid", {31'd0, valid_o}, 1);
    tick();
    chk("arst_tab_rep", {31'd0, done_o}, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
